mat_fetch_arbiter: RTL

//  Shares the single matrix-fetch port (A row + B column read) between NREQ algorithm

---
 rtl/mat_pkg.sv | 16 +
 rtl/rr_picker.sv | 28 ++
 rtl/mat_fetch_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared matrix-fetch types and dimensions used by the fetch arbiter and its clients.
package mat_pkg;

  localparam int DIM = 32;
  localparam int DW  = 8;
  localparam int AW  = $clog2(DIM);

  typedef logic [DIM-1:0][DW-1:0] mat_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            any
);

  int idx;

  // Scan offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[PW'(idx)]) begin
        grant = PW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mat_fetch_arbiter.sv
// Round-robin arbiter sharing one matrix-fetch port among NREQ engines, one fetch in flight.
module mat_fetch_arbiter
  import mat_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][AW-1:0]  req_row,
  input  logic [NREQ-1:0][AW-1:0]  req_col,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [AW-1:0]            rsp_row,
  output logic [AW-1:0]            rsp_col,
  output mat_vec_t                 rsp_matA_row,
  output mat_vec_t                 rsp_matB_col,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_row,
  output logic [AW-1:0]            mem_col,
  input  logic                     mem_valid,
  input  mat_vec_t                 mem_matA_row,
  input  mat_vec_t                 mem_matB_col,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_t    state_q, state_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   rsp_row_q, rsp_row_d;
  logic [AW-1:0]   rsp_col_q, rsp_col_d;
  mat_vec_t        rsp_a_q, rsp_a_d;
  mat_vec_t        rsp_b_q, rsp_b_d;
  logic            timeout_err_q, timeout_err_d;

  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [PW-1:0]   next_ptr;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign next_ptr = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_ptr_d      = rr_ptr_q;
    row_d         = row_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    mem_req_d     = 1'b0;
    rsp_row_d     = rsp_row_q;
    rsp_col_d     = rsp_col_q;
    rsp_a_d       = rsp_a_q;
    rsp_b_d       = rsp_b_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_idx;
          row_d       = req_row[pick_idx];
          col_d       = req_col[pick_idx];
          req_ready_d = NREQ'(1) << pick_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A late mem_valid on the final counted cycle still wins over the timeout.
        if (mem_valid) begin
          rsp_valid_d = NREQ'(1) << gnt_q;
          rsp_row_d   = row_q;
          rsp_col_d   = col_q;
          rsp_a_d     = mem_matA_row;
          rsp_b_d     = mem_matB_col;
          rr_ptr_d    = next_ptr;
          state_d     = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      mem_req_q     <= 1'b0;
      rsp_row_q     <= '0;
      rsp_col_q     <= '0;
      rsp_a_q       <= '0;
      rsp_b_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      mem_req_q     <= mem_req_d;
      rsp_row_q     <= rsp_row_d;
      rsp_col_q     <= rsp_col_d;
      rsp_a_q       <= rsp_a_d;
      rsp_b_q       <= rsp_b_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_row      = rsp_row_q;
  assign rsp_col      = rsp_col_q;
  assign rsp_matA_row = rsp_a_q;
  assign rsp_matB_col = rsp_b_q;
  assign mem_req      = mem_req_q;
  assign mem_row      = row_q;
  assign mem_col      = col_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = timeout_err_q;

endmodule
